// File: rtl/tb_obi_pkg.sv
// ============================================================================
// Package : tb_obi_pkg
// Shared OBI request/response types and index-width helper for the TB mux.
// Revision: 1.0
// ============================================================================
`default_nettype none

package tb_obi_pkg;

   localparam int unsigned OBI_ADDR_W     = 32;
   localparam int unsigned OBI_DATA_W     = 32;
   localparam int unsigned NR_MASTERS_DEF = 2;

   typedef struct packed {
      logic [OBI_ADDR_W-1:0]   addr;
      logic                    we;
      logic [OBI_DATA_W/8-1:0] be;
      logic [OBI_DATA_W-1:0]   wdata;
   } obi_req_t;

   typedef struct packed {
      logic [OBI_DATA_W-1:0] rdata;
   } obi_rsp_t;

   // A single master still needs a 1-bit index so vectors never collapse to zero width.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned IDX_W_DEF = idx_width(NR_MASTERS_DEF);

endpackage

`default_nettype wire

// File: rtl/tb_obi_idx_fifo.sv
// ============================================================================
// Module  : tb_obi_idx_fifo
// Synchronous FIFO of master indices used for in-order response routing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_obi_idx_fifo
   import tb_obi_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = IDX_W_DEF
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             w_push, w_pop;

   assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign data_o  = mem_q[rd_q];

   // Overflow/underflow requests are dropped so the pointers never desynchronise.
   assign w_push = push_i & ~full_o;
   assign w_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (w_push) wr_d = wr_q + PTR_W'(1);
      if (w_pop)  rd_d = rd_q + PTR_W'(1);
      if (w_push && !w_pop)      cnt_d = cnt_q + (PTR_W+1)'(1);
      else if (!w_push && w_pop) cnt_d = cnt_q - (PTR_W+1)'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) mem_q[wr_q] <= data_i;
   end

endmodule

`default_nettype wire

// File: rtl/tb_obi_rr_mux.sv
// ============================================================================
// Module  : tb_obi_rr_mux
// N-to-1 OBI round-robin request mux with locked selection and in-order
// response routing. Optional grant/stall counters under TB_OBI_MUX_STATS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_obi_rr_mux
   import tb_obi_pkg::*;
#(
   parameter int unsigned NR_MASTERS      = NR_MASTERS_DEF,
   parameter int unsigned ADDR_WIDTH      = OBI_ADDR_W,
   parameter int unsigned DATA_WIDTH      = OBI_DATA_W,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic [NR_MASTERS-1:0]               m_req_i,
   input  logic [NR_MASTERS*ADDR_WIDTH-1:0]    m_addr_i,
   input  logic [NR_MASTERS-1:0]               m_we_i,
   input  logic [NR_MASTERS*DATA_WIDTH/8-1:0]  m_be_i,
   input  logic [NR_MASTERS*DATA_WIDTH-1:0]    m_wdata_i,
   output logic [NR_MASTERS-1:0]               m_gnt_o,
   output logic [NR_MASTERS-1:0]               m_rvalid_o,
   output logic [NR_MASTERS*DATA_WIDTH-1:0]    m_rdata_o,
   output logic                                s_req_o,
   output logic [ADDR_WIDTH-1:0]               s_addr_o,
   output logic                                s_we_o,
   output logic [DATA_WIDTH/8-1:0]             s_be_o,
   output logic [DATA_WIDTH-1:0]               s_wdata_o,
   input  logic                                s_gnt_i,
   input  logic                                s_rvalid_i,
   input  logic [DATA_WIDTH-1:0]               s_rdata_i,
   output logic                                err_o
);

   localparam int unsigned IDX_W = idx_width(NR_MASTERS);
   localparam int unsigned BE_W  = DATA_WIDTH / 8;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   logic [IDX_W-1:0] rr_q, rr_d;
   logic             lock_q, lock_d;
   logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
   logic             err_q, err_d;

   logic [IDX_W-1:0] w_cand, w_rr_idx, w_sel, w_sel_nxt, w_head;
   logic             w_rr_found, w_any, w_grant;
   logic             w_fifo_full, w_fifo_empty, w_full;
   logic [CNT_W-1:0] w_count;

   // Round-robin search: first requester at or after the pointer.
   always_comb begin
      w_rr_found = 1'b0;
      w_rr_idx   = '0;
      w_cand     = '0;
      for (int unsigned k = 0; k < NR_MASTERS; k++) begin
         w_cand = IDX_W'((32'(rr_q) + k) % NR_MASTERS);
         if (!w_rr_found && m_req_i[w_cand]) begin
            w_rr_found = 1'b1;
            w_rr_idx   = w_cand;
         end
      end
   end

   assign w_any     = |m_req_i;
   assign w_sel     = (lock_q && m_req_i[lock_idx_q]) ? lock_idx_q : w_rr_idx;
   assign w_sel_nxt = (32'(w_sel) == NR_MASTERS - 1) ? '0 : w_sel + IDX_W'(1);
   assign w_full    = w_fifo_full | (32'(w_count) >= MAX_OUTSTANDING);

   // Qualified with rst_ni so nothing leaks onto the bus while reset is held.
   assign s_req_o   = rst_ni & w_any & ~w_full;
   assign w_grant   = s_req_o & s_gnt_i;

   assign s_addr_o  = s_req_o ? m_addr_i[w_sel*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign s_we_o    = s_req_o ? m_we_i[w_sel]                            : 1'b0;
   assign s_be_o    = s_req_o ? m_be_i[w_sel*BE_W +: BE_W]               : '0;
   assign s_wdata_o = s_req_o ? m_wdata_i[w_sel*DATA_WIDTH +: DATA_WIDTH] : '0;

   always_comb begin
      m_gnt_o        = '0;
      m_gnt_o[w_sel] = w_grant;
   end

   always_comb begin
      m_rvalid_o         = '0;
      m_rvalid_o[w_head] = s_rvalid_i & ~w_fifo_empty;
   end

   for (genvar gi = 0; gi < NR_MASTERS; gi++) begin : g_rdata
      assign m_rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = s_rdata_i;
   end

   always_comb begin
      rr_d       = rr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      err_d      = err_q | (s_rvalid_i & w_fifo_empty);
      if (w_grant) begin
         rr_d   = w_sel_nxt;
         lock_d = 1'b0;
      end else if (w_any) begin
         lock_d     = 1'b1;
         lock_idx_d = w_sel;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q       <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         err_q      <= 1'b0;
      end else begin
         rr_q       <= rr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         err_q      <= err_d;
      end
   end

   assign err_o = err_q;

   tb_obi_idx_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (IDX_W)
   ) u_idx_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_grant),
      .data_i  (w_sel),
      .pop_i   (s_rvalid_i),
      .data_o  (w_head),
      .count_o (w_count),
      .full_o  (w_fifo_full),
      .empty_o (w_fifo_empty)
   );

`ifdef TB_OBI_MUX_STATS_EN
   logic [31:0] grant_cnt_q [NR_MASTERS];
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < NR_MASTERS; i++) grant_cnt_q[i] <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (w_grant && (grant_cnt_q[w_sel] != '1))
            grant_cnt_q[w_sel] <= grant_cnt_q[w_sel] + 32'd1;
         if (w_any && !w_grant && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end
`else
`endif

endmodule

`default_nettype wire

// File: tb/tb_tb_obi_rr_mux.sv
// ============================================================================
// Module  : tb_tb_obi_rr_mux
// Directed scoreboard bench for tb_obi_rr_mux (2 masters, 4 outstanding).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tb_obi_rr_mux;
   import tb_obi_pkg::*;

   localparam int NM = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic              clk, rst_ni;
   logic [NM-1:0]     m_req, m_we, m_gnt, m_rvalid;
   logic [NM*AW-1:0]  m_addr;
   logic [NM*BW-1:0]  m_be;
   logic [NM*DW-1:0]  m_wdata, m_rdata;
   logic              s_req, s_we, s_gnt, s_rvalid, err;
   logic [AW-1:0]     s_addr;
   logic [BW-1:0]     s_be;
   logic [DW-1:0]     s_wdata, s_rdata;

   obi_req_t mreq [NM];

   typedef struct {
      int          idx;
      logic [31:0] val;
   } exp_t;

   exp_t gq[$];
   exp_t rq[$];
   int   total = 0;
   int   bad   = 0;
   int   gcnt [NM];

   tb_obi_rr_mux #(
      .NR_MASTERS      (NM),
      .ADDR_WIDTH      (AW),
      .DATA_WIDTH      (DW),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .m_req_i    (m_req),
      .m_addr_i   (m_addr),
      .m_we_i     (m_we),
      .m_be_i     (m_be),
      .m_wdata_i  (m_wdata),
      .m_gnt_o    (m_gnt),
      .m_rvalid_o (m_rvalid),
      .m_rdata_o  (m_rdata),
      .s_req_o    (s_req),
      .s_addr_o   (s_addr),
      .s_we_o     (s_we),
      .s_be_o     (s_be),
      .s_wdata_o  (s_wdata),
      .s_gnt_i    (s_gnt),
      .s_rvalid_i (s_rvalid),
      .s_rdata_i  (s_rdata),
      .err_o      (err)
   );

   always_comb begin
      for (int k = 0; k < NM; k++) begin
         m_addr[k*AW +: AW]  = mreq[k].addr;
         m_we[k]             = mreq[k].we;
         m_be[k*BW +: BW]    = mreq[k].be;
         m_wdata[k*DW +: DW] = mreq[k].wdata;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_gnt(input int idx, input logic [31:0] addr);
      gq.push_back('{idx: idx, val: addr});
   endtask

   task automatic exp_rsp(input int idx, input logic [31:0] data);
      rq.push_back('{idx: idx, val: data});
   endtask

   // Monitor: every grant / response the DUT presents is matched against the queues.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (m_gnt !== '0) begin
            if (m_gnt[0] === 1'b1) gcnt[0]++;
            if (m_gnt[1] === 1'b1) gcnt[1]++;
            if (gq.size() == 0) begin
               total++; bad++;
               $display("FAIL mon_gnt_unexpected: got %b expected none", m_gnt);
            end else begin
               e = gq.pop_front();
               chk("mon_gnt_idx", 32'(m_gnt), 32'(2'b01 << e.idx));
               chk("mon_gnt_addr", s_addr, e.val);
            end
         end
         if (m_rvalid !== '0) begin
            if (rq.size() == 0) begin
               total++; bad++;
               $display("FAIL mon_rsp_unexpected: got %b expected none", m_rvalid);
            end else begin
               e = rq.pop_front();
               chk("mon_rsp_idx", 32'(m_rvalid), 32'(2'b01 << e.idx));
               chk("mon_rsp_data", m_rdata[e.idx*DW +: DW], e.val);
            end
         end
      end
   end

   initial begin
      int ord [4] = '{0, 1, 1, 0};
      rst_ni = 1'b0; m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
      gcnt[0] = 0; gcnt[1] = 0;
      for (int k = 0; k < NM; k++) mreq[k] = '{addr: 32'h0, we: 1'b0, be: 4'hF, wdata: 32'h0};

      // Reset state
      @(negedge clk);
      chk("rst_s_req", 32'(s_req), 0);
      chk("rst_m_gnt", 32'(m_gnt), 0);
      chk("rst_m_rvalid", 32'(m_rvalid), 0);
      chk("rst_err", 32'(err), 0);
      repeat (2) step();
      rst_ni = 1'b1;

      // Single read from master 0
      mreq[0].addr = 32'h100;
      m_req = 2'b01; s_gnt = 1'b1; exp_gnt(0, 32'h100);
      @(negedge clk);
      chk("t1_gnt_same_cycle", 32'(m_gnt), 32'h1);
      step();
      m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF; exp_rsp(0, 32'hDEADBEEF);
      @(negedge clk);
      chk("t1_rvalid", 32'(m_rvalid), 32'h1);
      step();
      s_rvalid = 1'b0;

      // Fairness: both masters request every cycle from a fresh pointer
      rst_ni = 1'b0; step(); rst_ni = 1'b1;
      gcnt[0] = 0; gcnt[1] = 0;
      mreq[0].addr = 32'h1000; mreq[1].addr = 32'h2000;
      for (int i = 0; i < 100; i++) begin
         m_req = 2'b11; s_gnt = 1'b1; s_rvalid = (i > 0); s_rdata = 32'(i);
         exp_gnt(i % 2, (i % 2) ? 32'h2000 : 32'h1000);
         if (i > 0) exp_rsp((i - 1) % 2, 32'(i));
         step();
      end
      m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'd100; exp_rsp(1, 32'd100);
      step();
      s_rvalid = 1'b0;
      chk("t2_cnt_m0", 32'(gcnt[0]), 50);
      chk("t2_cnt_m1", 32'(gcnt[1]), 50);

      // Lock: master 1 held off by slave, master 0 joins; selection must not move
      mreq[0].addr = 32'h1230; mreq[1].addr = 32'h2340;
      m_req = 2'b10; s_gnt = 1'b0;
      @(negedge clk);
      chk("t3_addr_first", s_addr, 32'h2340);
      step();
      m_req = 2'b11;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_addr_locked", s_addr, 32'h2340);
         chk("t3_no_gnt", 32'(m_gnt), 0);
         step();
      end
      s_gnt = 1'b1; exp_gnt(1, 32'h2340);
      step();
      m_req = 2'b01; exp_gnt(0, 32'h1230);
      step();
      m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h11; exp_rsp(1, 32'h11);
      step();
      s_rdata = 32'h22; exp_rsp(0, 32'h22);
      step();
      s_rvalid = 1'b0;

      // FIFO full stall, even with a pop in the same cycle
      m_req = 2'b01; s_gnt = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mreq[0].addr = 32'h300 + 32'(4 * i);
         exp_gnt(0, mreq[0].addr);
         step();
      end
      mreq[0].addr = 32'h310; s_rvalid = 1'b1; s_rdata = 32'h40; exp_rsp(0, 32'h40);
      @(negedge clk);
      chk("t4_full_s_req", 32'(s_req), 0);
      chk("t4_full_gnt", 32'(m_gnt), 0);
      step();
      s_rvalid = 1'b0; exp_gnt(0, 32'h310);
      @(negedge clk);
      chk("t4_resume_s_req", 32'(s_req), 1);
      step();
      m_req = '0; s_gnt = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         s_rvalid = 1'b1; s_rdata = 32'h40 + 32'(i); exp_rsp(0, s_rdata);
         step();
      end
      s_rvalid = 1'b0;

      // Interleaved grants 0,1,1,0 with delayed in-order responses
      mreq[0].addr = 32'h500; mreq[1].addr = 32'h600; s_gnt = 1'b1;
      for (int i = 0; i < 4; i++) begin
         m_req = 2'b01 << ord[i];
         exp_gnt(ord[i], ord[i] ? 32'h600 : 32'h500);
         step();
      end
      m_req = '0; s_gnt = 1'b0;
      repeat (2) step();
      for (int i = 0; i < 4; i++) begin
         s_rvalid = 1'b1; s_rdata = 32'hA0 + 32'(i); exp_rsp(ord[i], s_rdata);
         @(negedge clk);
         chk("t5_rvalid_order", 32'(m_rvalid), 32'(2'b01 << ord[i]));
         step();
      end
      s_rvalid = 1'b0;

      // Spurious response sets a sticky error
      s_rvalid = 1'b1; s_rdata = 32'h55;
      @(negedge clk);
      chk("t6_spurious_no_rvalid", 32'(m_rvalid), 0);
      step();
      s_rvalid = 1'b0;
      @(negedge clk);
      chk("t6_err_set", 32'(err), 1);
      repeat (3) step();
      @(negedge clk);
      chk("t6_err_sticky", 32'(err), 1);
      step();

      // Reset mid-burst: outstanding master-1 response is discarded
      mreq[0].addr = 32'h700; mreq[1].addr = 32'h800;
      m_req = 2'b11; s_gnt = 1'b1; exp_gnt(1, 32'h800);
      step();
      rst_ni = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h99;
      @(negedge clk);
      chk("t7_rst_s_req", 32'(s_req), 0);
      chk("t7_rst_gnt", 32'(m_gnt), 0);
      chk("t7_rst_rvalid", 32'(m_rvalid), 0);
      chk("t7_rst_err", 32'(err), 0);
      chk("t7_rst_addr", s_addr, 0);
      step();
      rst_ni = 1'b1; s_rvalid = 1'b0; exp_gnt(0, 32'h700);
      step();
      m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h77; exp_rsp(0, 32'h77);
      @(negedge clk);
      chk("t7_fifo_cleared", 32'(m_rvalid), 32'h1);
      step();
      s_rvalid = 1'b0;
      repeat (2) step();

      chk("end_gnt_queue_empty", 32'(gq.size()), 0);
      chk("end_rsp_queue_empty", 32'(rq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
